gold_nic: RTL and testbench

- Network interface controller between the gold processor's NIC port and the on-chip router's local port.
- The processor reads and writes four memory-mapped NIC registers through addr/nicEn/nicEnWr.
- The NIC holds one inbound and one outbound 64-bit packet and runs the ready/send handshake toward the router.
- Outbound injection is gated by virtual-channel polarity.

---
 rtl/gold_nic_if.sv | 37 +++
 rtl/gold_nic.sv | 99 +++++++++
 tb/tb_gold_nic.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gold_nic_if.sv
`default_nettype none
// ============================================================================
// Module   : gold_nic_if
// Brief    : Processor-register and router-port bundle for the gold NIC.
// Revision : 1.0  initial release
// ============================================================================
interface gold_nic_if #(
  parameter int DATA_WIDTH = 64
);
  // Processor side
  logic [1:0]              addr;
  logic [0:DATA_WIDTH-1]   d_in;
  logic [0:DATA_WIDTH-1]   d_out;
  logic                    nicEn;
  logic                    nicEnWr;
  // Router side
  logic                    net_si;
  logic                    net_ri;
  logic [0:DATA_WIDTH-1]   net_di;
  logic                    net_so;
  logic                    net_ro;
  logic [0:DATA_WIDTH-1]   net_do;
  logic                    net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicEnWr,
    input  net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicEnWr,
    output net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface
`default_nettype wire

// File: rtl/gold_nic.sv
`default_nettype none
// ============================================================================
// Module   : gold_nic
// Brief    : One-deep inbound/outbound packet NIC between processor and router.
// Revision : 1.0  initial release
// ============================================================================
module gold_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 0
) (
  input  logic        clk,
  input  logic        reset,
  gold_nic_if.slave   nic
);

  localparam logic [1:0] C_ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] C_ADDR_IN_STS  = 2'b01;
  localparam logic [1:0] C_ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] C_ADDR_OUT_STS = 2'b11;

  logic [0:DATA_WIDTH-1] in_buf_q,  in_buf_d;
  logic [0:DATA_WIDTH-1] out_buf_q, out_buf_d;
  logic                  in_full_q, in_full_d;
  logic                  out_full_q, out_full_d;

  logic                  w_net_ri;
  logic                  w_net_so;
  logic                  w_rd;
  logic                  w_in_accept;
  logic                  w_rd_clear;
  logic                  w_out_write;
  logic [0:DATA_WIDTH-1] w_d_out;

  assign w_net_ri    = ~in_full_q;
  assign w_rd        = nic.nicEn & ~nic.nicEnWr;
  assign w_in_accept = nic.net_si & w_net_ri;
  assign w_rd_clear  = w_rd & (nic.addr == C_ADDR_IN_BUF) & in_full_q;
  // Write is qualified by the pre-edge full flag, so a write racing a send is dropped.
  assign w_out_write = nic.nicEn & nic.nicEnWr & (nic.addr == C_ADDR_OUT_BUF) & ~out_full_q;
  assign w_net_so    = out_full_q & nic.net_ro & (out_buf_q[VC_BIT] == nic.net_polarity);

  // Accept needs empty and read-clear needs full, so the two never coincide.
  always_comb begin
    in_buf_d  = in_buf_q;
    in_full_d = in_full_q;
    if (w_in_accept) begin
      in_buf_d  = nic.net_di;
      in_full_d = 1'b1;
    end else if (w_rd_clear) begin
      in_full_d = 1'b0;
    end
  end

  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    if (w_net_so) begin
      out_full_d = 1'b0;
    end else if (w_out_write) begin
      out_buf_d  = nic.d_in;
      out_full_d = 1'b1;
    end
  end

  // Status flags land in the last bit (LSB under MSB-first ordering).
  always_comb begin
    w_d_out = '0;
    if (w_rd) begin
      case (nic.addr)
        C_ADDR_IN_BUF:  w_d_out = in_buf_q;
        C_ADDR_IN_STS:  w_d_out = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
        C_ADDR_OUT_BUF: w_d_out = '0;
        C_ADDR_OUT_STS: w_d_out = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
        default:        w_d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end

  assign nic.net_ri = w_net_ri;
  assign nic.net_so = w_net_so;
  assign nic.net_do = out_buf_q;
  assign nic.d_out  = w_d_out;

endmodule
`default_nettype wire

// File: tb/tb_gold_nic.sv
`default_nettype none
// ============================================================================
// Module   : tb_gold_nic
// Brief    : Directed self-checking bench for gold_nic.
// Revision : 1.0  initial release
// ============================================================================
module tb_gold_nic;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gold_nic_if #(.DATA_WIDTH(64)) nic_if ();

  gold_nic #(.DATA_WIDTH(64), .VC_BIT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .nic   (nic_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cpu();
    nic_if.nicEn   = 1'b0;
    nic_if.nicEnWr = 1'b0;
    nic_if.addr    = 2'b00;
    nic_if.d_in    = '0;
  endtask

  task automatic set_read(input logic [1:0] a);
    nic_if.nicEn   = 1'b1;
    nic_if.nicEnWr = 1'b0;
    nic_if.addr    = a;
    #1;
  endtask

  task automatic set_write(input logic [63:0] v);
    nic_if.nicEn   = 1'b1;
    nic_if.nicEnWr = 1'b1;
    nic_if.addr    = 2'b10;
    nic_if.d_in    = v;
  endtask

  task automatic test_reset();
    idle_cpu();
    nic_if.net_si = 1'b0; nic_if.net_di = '0;
    nic_if.net_ro = 1'b0; nic_if.net_polarity = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (nic_if.net_ri !== 1'b1) begin errors++; $display("FAIL rst_ri_during got %b exp 1", nic_if.net_ri); end
    reset = 1'b1;
    #1;
    checks++;
    if (nic_if.net_ri !== 1'b1) begin errors++; $display("FAIL rst_ri got %b exp 1", nic_if.net_ri); end
    checks++;
    if (nic_if.net_so !== 1'b0) begin errors++; $display("FAIL rst_so got %b exp 0", nic_if.net_so); end
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL rst_dout got %h exp 0", nic_if.d_out); end
    checks++;
    if (nic_if.net_do !== 64'h0) begin errors++; $display("FAIL rst_do got %h exp 0", nic_if.net_do); end
    set_read(2'b01);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL rst_insts got %h exp 0", nic_if.d_out); end
    set_read(2'b11);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL rst_outsts got %h exp 0", nic_if.d_out); end
    idle_cpu();
  endtask

  task automatic test_inbound();
    step();
    nic_if.net_si = 1'b1;
    nic_if.net_di = 64'hDEAD_BEEF_0000_0001;
    step();
    nic_if.net_si = 1'b0;
    checks++;
    if (nic_if.net_ri !== 1'b0) begin errors++; $display("FAIL in_ri_full got %b exp 0", nic_if.net_ri); end
    set_read(2'b01);
    checks++;
    if (nic_if.d_out !== 64'h1) begin errors++; $display("FAIL in_sts_full got %h exp 1", nic_if.d_out); end
    set_read(2'b10);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL rd_outbuf got %h exp 0", nic_if.d_out); end
    set_read(2'b00);
    checks++;
    if (nic_if.d_out !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL in_data got %h exp deadbeef00000001", nic_if.d_out); end
    step();
    idle_cpu();
    #1;
    checks++;
    if (nic_if.net_ri !== 1'b1) begin errors++; $display("FAIL in_ri_clear got %b exp 1", nic_if.net_ri); end
    set_read(2'b01);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL in_sts_clear got %h exp 0", nic_if.d_out); end
    idle_cpu();
  endtask

  task automatic test_outbound_polarity();
    nic_if.net_ro = 1'b1;
    nic_if.net_polarity = 1'b0;
    set_write(64'h8000_0000_0000_00AA);
    step();
    idle_cpu();
    #1;
    checks++;
    if (nic_if.net_so !== 1'b0) begin errors++; $display("FAIL pol_block_so got %b exp 0", nic_if.net_so); end
    set_read(2'b11);
    checks++;
    if (nic_if.d_out !== 64'h1) begin errors++; $display("FAIL pol_outsts got %h exp 1", nic_if.d_out); end
    idle_cpu();
    step();
    checks++;
    if (nic_if.net_so !== 1'b0) begin errors++; $display("FAIL pol_hold_so got %b exp 0", nic_if.net_so); end
    nic_if.net_polarity = 1'b1;
    #1;
    checks++;
    if (nic_if.net_so !== 1'b1) begin errors++; $display("FAIL pol_match_so got %b exp 1", nic_if.net_so); end
    checks++;
    if (nic_if.net_do !== 64'h8000_0000_0000_00AA) begin errors++; $display("FAIL pol_do got %h exp 80000000000000aa", nic_if.net_do); end
    step();
    checks++;
    if (nic_if.net_so !== 1'b0) begin errors++; $display("FAIL pol_sent_so got %b exp 0", nic_if.net_so); end
    set_read(2'b11);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL pol_sent_sts got %h exp 0", nic_if.d_out); end
    idle_cpu();
    nic_if.net_polarity = 1'b0;
    nic_if.net_ro = 1'b0;
  endtask

  task automatic test_write_when_full();
    set_write(64'h1);
    step();
    set_write(64'h2);
    step();
    idle_cpu();
    #1;
    checks++;
    if (nic_if.net_do !== 64'h1) begin errors++; $display("FAIL wfull_kept got %h exp 1", nic_if.net_do); end
    nic_if.net_ro = 1'b1;
    #1;
    checks++;
    if (nic_if.net_so !== 1'b1) begin errors++; $display("FAIL wfull_so got %b exp 1", nic_if.net_so); end
    step();
    nic_if.net_ro = 1'b0;
    set_read(2'b11);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL wfull_drained got %h exp 0", nic_if.d_out); end
    set_write(64'h3);
    step();
    idle_cpu();
    #1;
    checks++;
    if (nic_if.net_do !== 64'h3) begin errors++; $display("FAIL wfull_next got %h exp 3", nic_if.net_do); end
    set_read(2'b11);
    checks++;
    if (nic_if.d_out !== 64'h1) begin errors++; $display("FAIL wfull_next_sts got %h exp 1", nic_if.d_out); end
    idle_cpu();
    nic_if.net_ro = 1'b1;
    step();
    nic_if.net_ro = 1'b0;
  endtask

  task automatic test_simultaneous();
    nic_if.net_si = 1'b1;
    nic_if.net_di = 64'h11;
    step();
    nic_if.net_di = 64'h55;
    set_read(2'b00);
    checks++;
    if (nic_if.d_out !== 64'h11) begin errors++; $display("FAIL sim_old_data got %h exp 11", nic_if.d_out); end
    checks++;
    if (nic_if.net_ri !== 1'b0) begin errors++; $display("FAIL sim_ri_busy got %b exp 0", nic_if.net_ri); end
    step();
    idle_cpu();
    #1;
    checks++;
    if (nic_if.net_ri !== 1'b1) begin errors++; $display("FAIL sim_not_taken got %b exp 1", nic_if.net_ri); end
    step();
    nic_if.net_si = 1'b0;
    checks++;
    if (nic_if.net_ri !== 1'b0) begin errors++; $display("FAIL sim_taken got %b exp 0", nic_if.net_ri); end
    set_read(2'b00);
    checks++;
    if (nic_if.d_out !== 64'h55) begin errors++; $display("FAIL sim_new_data got %h exp 55", nic_if.d_out); end
    step();
    idle_cpu();
    // Outbound: send and write share an edge.
    set_write(64'hA0);
    step();
    nic_if.net_ro = 1'b1;
    nic_if.net_polarity = 1'b0;
    set_write(64'hB0);
    #1;
    checks++;
    if (nic_if.net_so !== 1'b1) begin errors++; $display("FAIL sim_so got %b exp 1", nic_if.net_so); end
    step();
    nic_if.net_ro = 1'b0;
    set_read(2'b11);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL sim_wr_drop_sts got %h exp 0", nic_if.d_out); end
    checks++;
    if (nic_if.net_do !== 64'hA0) begin errors++; $display("FAIL sim_wr_drop_buf got %h exp a0", nic_if.net_do); end
    idle_cpu();
  endtask

  task automatic test_async_reset();
    nic_if.net_si = 1'b1;
    nic_if.net_di = 64'h77;
    set_write(64'h8000_0000_0000_0001);
    step();
    nic_if.net_si = 1'b0;
    idle_cpu();
    nic_if.net_ro = 1'b1;
    nic_if.net_polarity = 1'b1;
    #1;
    checks++;
    if (nic_if.net_so !== 1'b1) begin errors++; $display("FAIL ar_pre_so got %b exp 1", nic_if.net_so); end
    checks++;
    if (nic_if.net_ri !== 1'b0) begin errors++; $display("FAIL ar_pre_ri got %b exp 0", nic_if.net_ri); end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (nic_if.net_so !== 1'b0) begin errors++; $display("FAIL ar_so got %b exp 0", nic_if.net_so); end
    checks++;
    if (nic_if.net_ri !== 1'b1) begin errors++; $display("FAIL ar_ri got %b exp 1", nic_if.net_ri); end
    checks++;
    if (nic_if.net_do !== 64'h0) begin errors++; $display("FAIL ar_do got %h exp 0", nic_if.net_do); end
    set_read(2'b01);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL ar_insts got %h exp 0", nic_if.d_out); end
    set_read(2'b11);
    checks++;
    if (nic_if.d_out !== 64'h0) begin errors++; $display("FAIL ar_outsts got %h exp 0", nic_if.d_out); end
    idle_cpu();
    nic_if.net_ro = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    test_reset();
    test_inbound();
    test_outbound_polarity();
    test_write_when_full();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
